// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_BY_ZERO_QUOTIENT = {DIV_WIDTH_DEFAULT{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// try subtracting the divisor magnitude, keep the result only if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    assign shifted_s = {rem_i, dvd_bit_i};
    assign trial_s   = shifted_s - {1'b0, dmag_i};

    // A negative trial means the shifted remainder is below the divisor: restore.
    always_comb begin
        if (trial_s[WIDTH] == 1'b0) begin
            rem_o   = trial_s[WIDTH-1:0];
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s[WIDTH-1:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative radix-2 restoring signed divider with start/busy/done handshake.
// Optional macro DIV_UNSIGNED_EN adds an is_signed input for unsigned operation.
module seq_signed_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic            dbz_q, dbz_d;

    logic            sa_s, sb_s;
    logic [WIDTH-1:0] step_rem_s;
    logic            step_bit_s;

`ifdef DIV_UNSIGNED_EN
    assign sa_s = is_signed & dividend[WIDTH-1];
    assign sb_s = is_signed & divisor[WIDTH-1];
`else
    assign sa_s = dividend[WIDTH-1];
    assign sb_s = divisor[WIDTH-1];
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dq_q[WIDTH-1]),
        .dmag_i    (dmag_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_bit_s)
    );

    // Next-state and datapath control; dq holds the dividend magnitude and
    // fills with quotient bits from the right as it shifts out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dmag_d  = dmag_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_neg_d = sa_s ^ sb_s;
                    r_neg_d = sa_s;
                    dmag_d  = neg_if(divisor, sb_s);
                    dq_d    = neg_if(dividend, sa_s);
                    dbz_d   = 1'b0;
                    if (divisor == {WIDTH{1'b0}}) begin
                        // rem holds the raw dividend so FIX can return it unchanged.
                        dz_d    = 1'b1;
                        rem_d   = dividend;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = {WIDTH{1'b0}};
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = step_rem_s;
                dq_d  = {dq_q[WIDTH-2:0], step_bit_s};
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            FIX: begin
                if (dz_q) begin
                    quot_d = {WIDTH{1'b1}};
                    rmd_d  = rem_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = neg_if(dq_q, q_neg_q);
                    rmd_d  = neg_if(rem_q, r_neg_q);
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dq_q    <= {WIDTH{1'b0}};
            dmag_q  <= {WIDTH{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rmd_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dmag_q  <= dmag_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random self-checking bench for seq_signed_divider (WIDTH = 32).
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge; returns at #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait for done; cyc is the done cycle index counted from the accepting edge.
    task automatic wait_done(input bit poke, output int cyc);
        int n;
        n   = 0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (poke && n == 5) begin
                start    = 1'b1;
                dividend = 32'hFFFF_FFCE;
                divisor  = 32'h0000_0003;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) begin
                cyc = n + 1;
                break;
            end
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz, input int elat, input bit poke);
        int cyc;
        issue(a, b);
        wait_done(poke, cyc);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        check("done_cycle", cyc, elat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        int a, b, eq, er;
        longint abs_r, abs_b;

        rst      = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34, 1'b0);
        run_op(32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 2, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
        run_op(32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 32'd0, 1'b0, 34, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 34, 1'b0);
        run_op(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 34, 1'b1);
        run_op(32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 2, 1'b0);

        // Abort a fresh operation with reset at T+10.
        issue(32'd500, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        run_op(32'd500, 32'd3, 32'd166, 32'd2, 1'b0, 34, 1'b0);

        // Random signed pairs, issued in the cycle after each done.
        for (int k = 0; k < 200; k++) begin
            a = $urandom;
            b = (k % 3 == 0) ? (int'($urandom_range(0, 30)) - 15) : int'($urandom);
            if (k % 5 == 0) a = int'($urandom_range(0, 200)) - 100;
            if (b == 0) b = 1;
            if (a == 32'sh8000_0000 && b == -1) b = 1;
            eq = a / b;
            er = a % b;
            issue(a, b);
            wait_done(1'b0, cyc);
            check("rnd_quotient", quotient, eq);
            check("rnd_remainder", remainder, er);
            check("rnd_identity", quotient * b + remainder, a);
            check("rnd_rem_sign", {31'd0, (remainder == 32'd0) || (remainder[31] == a[31])}, 32'd1);
            abs_r = $signed(remainder);
            abs_b = b;
            if (abs_r < 0) abs_r = -abs_r;
            if (abs_b < 0) abs_b = -abs_b;
            check("rnd_rem_mag", {31'd0, abs_r < abs_b}, 32'd1);
            check("rnd_done_cycle", cyc, 34);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
